// File: rtl/ysyx_23060332_dmem_resp_pkg.sv
// Shared bus widths, write-enable encodings and FSM state encodings for the
// ysyx_23060332 data-memory responder.
package ysyx_23060332_dmem_resp_pkg;

   localparam int MemAddrBus = 32;
   localparam int MemDataBus = 32;

   localparam logic WriteEnable  = 1'b1;
   localparam logic WriteDisable = 1'b0;

   localparam logic [MemDataBus-1:0] ZeroWord = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

endpackage

// File: rtl/ysyx_23060332_dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Only the read register is reset; the array contents are left uninitialised.
module ysyx_23060332_dmem_ram #(
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   localparam int IDX_W      = $clog2(DEPTH_WORDS),
   localparam int NB         = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [IDX_W-1:0]  idx,
   input  logic [NB-1:0]     be,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
   logic [DATA_W-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
               mem_q[idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q <= '0;
      end else if (re) begin
         rd_q <= mem_q[idx];
      end
   end

   assign rdata = rd_q;

endmodule

// File: rtl/ysyx_23060332_dmem_resp.sv
// Data-memory responder: one request at a time, fixed LATENCY, byte-masked stores.
// Define YSYX_23060332_DMEM_ERR_EN to flag out-of-range addresses on mem_err.
module ysyx_23060332_dmem_resp
   import ysyx_23060332_dmem_resp_pkg::*;
#(
   parameter int DATA_W      = MemDataBus,
   parameter int ADDR_W      = MemAddrBus,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_valid,
   input  logic              mem_wen,
   input  logic [ADDR_W-1:0] mem_waddr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [7:0]        mem_wmask,
   input  logic [ADDR_W-1:0] mem_raddr,
   output logic              mem_ready,
   output logic              mem_rvalid,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_wdone,
   output logic              mem_err
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

   dmem_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [NB-1:0]     mask_q, mask_d;
   logic              err_q, err_d;
   logic              rzero_q, rzero_d;

   logic              acc_en;
   logic              acc_wen;
   logic              acc_oob;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic [NB-1:0]     acc_mask;
   logic [DATA_W-1:0] ram_rdata;
   logic              mask_unused;
   logic              addr_unused;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wen_d     = wen_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      mask_d    = mask_q;
      acc_en    = 1'b0;
      acc_wen   = WriteDisable;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_mask  = mask_q;
      case (state_q)
         IDLE: begin
            if (mem_valid) begin
               wen_d   = mem_wen;
               addr_d  = mem_wen ? mem_waddr : mem_raddr;
               wdata_d = mem_wdata;
               mask_d  = mem_wmask[NB-1:0];
               // With single-cycle latency the access happens on the accept edge.
               if (LATENCY == 1) begin
                  acc_en    = 1'b1;
                  acc_wen   = mem_wen;
                  acc_addr  = addr_d;
                  acc_wdata = mem_wdata;
                  acc_mask  = mem_wmask[NB-1:0];
                  state_d   = RESP;
               end else begin
                  cnt_d   = CNT_INIT;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               acc_en  = 1'b1;
               acc_wen = wen_q;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef YSYX_23060332_DMEM_ERR_EN
   assign acc_oob = (acc_addr[ADDR_W-1:IDX_W+2] != '0);
`else
   assign acc_oob = 1'b0;
`endif

   assign err_d   = acc_en ? acc_oob : err_q;
   // Remembers whether the last load failed so mem_rdata stays 0 until the next load.
   assign rzero_d = (acc_en && acc_wen == WriteDisable) ? acc_oob : rzero_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wen_q   <= WriteDisable;
         addr_q  <= '0;
         wdata_q <= '0;
         mask_q  <= '0;
         err_q   <= 1'b0;
         rzero_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         mask_q  <= mask_d;
         err_q   <= err_d;
         rzero_q <= rzero_d;
      end
   end

   ysyx_23060332_dmem_ram #(
      .DATA_W      (DATA_W),
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (acc_en && acc_wen == WriteEnable && !acc_oob && !rst),
      .re    (acc_en && acc_wen == WriteDisable && !rst),
      .idx   (acc_addr[IDX_W+1:2]),
      .be    (acc_mask),
      .wdata (acc_wdata),
      .rdata (ram_rdata)
   );

   assign mem_ready  = (state_q == IDLE);
   assign mem_rvalid = (state_q == RESP) && !wen_q;
   assign mem_wdone  = (state_q == RESP) && wen_q;
   assign mem_err    = (state_q == RESP) && err_q;
   assign mem_rdata  = rzero_q ? ZeroWord : ram_rdata;

   assign mask_unused = ^mem_wmask;
   assign addr_unused = ^acc_addr;

endmodule

// File: tb/tb_ysyx_23060332_dmem_resp.sv
// Scoreboard bench for ysyx_23060332_dmem_resp: stimulus pushes expected
// responses, a negedge monitor pops and compares them on every response pulse.
module tb_ysyx_23060332_dmem_resp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_valid = 1'b0;
   logic        mem_wen = 1'b0;
   logic [31:0] mem_waddr = '0;
   logic [31:0] mem_wdata = '0;
   logic [7:0]  mem_wmask = '0;
   logic [31:0] mem_raddr = '0;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        mem_wdone;
   logic        mem_err;

   typedef struct packed {
      logic        is_load;
      logic        chk_data;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   total_cnt = 0;
   int   pass_cnt  = 0;
   int   resp_cnt  = 0;
   int   base;

`ifdef YSYX_23060332_DMEM_ERR_EN
   localparam logic        OOB_ERR  = 1'b1;
   localparam logic [31:0] OOB_DATA = 32'h0000_0000;
`else
   localparam logic        OOB_ERR  = 1'b0;
   localparam logic [31:0] OOB_DATA = 32'hCAFE_F00D;
`endif

   always #5 clk = ~clk;

   ysyx_23060332_dmem_resp dut (
      .clk        (clk),
      .rst        (rst),
      .mem_valid  (mem_valid),
      .mem_wen    (mem_wen),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .mem_wmask  (mem_wmask),
      .mem_raddr  (mem_raddr),
      .mem_ready  (mem_ready),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .mem_wdone  (mem_wdone),
      .mem_err    (mem_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
         $display("ok   %s got=0x%08h", name, act);
      end else begin
         $display("FAIL %s got=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (mem_rvalid || mem_wdone)) begin
         resp_cnt++;
         if (q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_resp got rvalid=%0b wdone=%0b expected no response",
                     mem_rvalid, mem_wdone);
         end else begin
            e = q.pop_front();
            check("resp_kind", {30'd0, mem_rvalid, mem_wdone}, {30'd0, e.is_load, !e.is_load});
            if (e.is_load && e.chk_data) check("rdata", mem_rdata, e.data);
            check("err", {31'd0, mem_err}, {31'd0, e.err});
         end
      end
   end

   task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [7:0] mask, input logic push, input logic chk,
                        input logic [31:0] exp_data, input logic exp_err);
      int budget;
      mem_wen   = wen;
      mem_waddr = wen ? addr : 32'h0000_0FFC;
      mem_raddr = wen ? 32'h0000_0FF8 : addr;
      mem_wdata = wdata;
      mem_wmask = mask;
      mem_valid = 1'b1;
      budget = 0;
      while (!mem_ready && budget < 20) begin
         @(posedge clk); #1;
         budget++;
      end
      if (!mem_ready) begin
         total_cnt++;
         $display("FAIL accept_timeout got ready=0 expected ready=1 within 20 cycles");
         mem_valid = 1'b0;
         return;
      end
      if (push) q.push_back('{!wen, chk, exp_data, exp_err});
      @(posedge clk); #1;
      mem_valid = 1'b0;
   endtask

   task automatic drain();
      int budget = 0;
      while (!(q.size() == 0 && mem_ready) && budget < 100) begin
         @(posedge clk); #1;
         budget++;
      end
      if (q.size() != 0 || !mem_ready) begin
         total_cnt++;
         $display("FAIL drain_timeout got pending=%0d expected pending=0", q.size());
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_ready",  {31'd0, mem_ready},  32'd1);
      check("rst_rvalid", {31'd0, mem_rvalid}, 32'd0);
      check("rst_wdone",  {31'd0, mem_wdone},  32'd0);
      check("rst_err",    {31'd0, mem_err},    32'd0);
      check("rst_rdata",  mem_rdata,           32'd0);

      // Latency: accept at T, busy at T+1, pulse at T+2, ready again afterwards
      issue(1'b0, 32'h0, 32'h0, 8'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      check("t1_ready",  {31'd0, mem_ready},  32'd0);
      check("t1_rvalid", {31'd0, mem_rvalid}, 32'd0);
      @(posedge clk); #1;
      check("t2_ready",  {31'd0, mem_ready},  32'd0);
      check("t2_rvalid", {31'd0, mem_rvalid}, 32'd1);
      check("t2_wdone",  {31'd0, mem_wdone},  32'd0);
      @(posedge clk); #1;
      check("t3_ready",  {31'd0, mem_ready},  32'd1);
      check("t3_rvalid", {31'd0, mem_rvalid}, 32'd0);

      // Back-to-back requests: the second is held during BUSY/RESP
      base = resp_cnt;
      issue(1'b1, 32'h10, 32'hDEAD_BEEF, 8'h0F, 1'b1, 1'b0, 32'h0, 1'b0);
      issue(1'b0, 32'h10, 32'h0, 8'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
      drain();
      check("two_pulses", resp_cnt - base, 32'd2);

      issue(1'b1, 32'h10, 32'h1122_3344, 8'h05, 1'b1, 1'b0, 32'h0, 1'b0);
      issue(1'b0, 32'h13, 32'h0, 8'h0, 1'b1, 1'b1, 32'hDE22_BE44, 1'b0);
      issue(1'b1, 32'h10, 32'hFFFF_FFFF, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);
      issue(1'b0, 32'h10, 32'h0, 8'h0, 1'b1, 1'b1, 32'hDE22_BE44, 1'b0);
      drain();

      // Reset one cycle after a store is accepted drops that store
      issue(1'b1, 32'h20, 32'hAAAA_5555, 8'h0F, 1'b1, 1'b0, 32'h0, 1'b0);
      issue(1'b0, 32'h20, 32'h0, 8'h0, 1'b1, 1'b1, 32'hAAAA_5555, 1'b0);
      drain();
      issue(1'b1, 32'h20, 32'h1234_5678, 8'h0F, 1'b0, 1'b0, 32'h0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_ready", {31'd0, mem_ready}, 32'd1);
      check("abort_rdata", mem_rdata, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      issue(1'b0, 32'h20, 32'h0, 8'h0, 1'b1, 1'b1, 32'hAAAA_5555, 1'b0);
      drain();

      // Out-of-range address: error response or wrap to word 0
      issue(1'b1, 32'h0, 32'hCAFE_F00D, 8'h0F, 1'b1, 1'b0, 32'h0, 1'b0);
      issue(1'b0, 32'h1000, 32'h0, 8'h0, 1'b1, 1'b1, OOB_DATA, OOB_ERR);
      issue(1'b0, 32'h0, 32'h0, 8'h0, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0);
      drain();

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ysyx_23060332_dmem_resp.md
# ysyx_23060332_dmem_resp

Data-memory responder for the ysyx_23060332 core: the slave end of the execute unit's memory request interface (`mem_valid`/`mem_wen`/`mem_waddr`/`mem_wdata`/`mem_wmask`/`mem_raddr` in, `mem_rdata` out). It accepts one load or store at a time, models a configurable fixed access latency, and commits byte-masked writes into a word-organised RAM. It signals completion with a one-cycle response pulse, and it lets the core or pipeline controller stall on `mem_ready`.

## Interface
- Clock and reset: one clock; reset is synchronous and active-high.

Parameters:
- `DATA_W`, 32, data width; must equal `MemDataBus` width.
- `ADDR_W`, 32, byte-address width; must equal `MemAddrBus` width.
- `DEPTH_WORDS`, 1024, RAM size in `DATA_W`-bit words; power of two.
- `LATENCY`, 2, cycles from accept to response pulse; must be ≥1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `mem_valid`  in  1  request present.
- `mem_wen`  in  1  1 = store, 0 = load; sampled with `mem_valid`.
- `mem_waddr`  in  ADDR_W  store byte address.
- `mem_wdata`  in  DATA_W  store data.
- `mem_wmask`  in  8  byte enables; bit i selects byte i; bits above DATA_W/8 are ignored.
- `mem_raddr`  in  ADDR_W  load byte address.
- `mem_ready`  out  1  request can be accepted this cycle.
- `mem_rvalid`  out  1  one-cycle pulse: load data valid.
- `mem_rdata`  out  DATA_W  load data; held until the next load response.
- `mem_wdone`  out  1  one-cycle pulse: store committed.
- `mem_err`  out  1  one-cycle pulse with rvalid/wdone: address out of range (only with the macro).

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: `mem_ready`=1. If `mem_valid`, the request is accepted and these are captured: wen, the selected address (`mem_waddr` if wen, else `mem_raddr`), wdata, and mask.
  - If LATENCY=1, go to RESP.
  - Otherwise load `cnt`=LATENCY-2 and go to BUSY.
- BUSY: `mem_ready`=0.
  - If `cnt`==0, perform the access and go to RESP.
  - Otherwise `cnt`--.
  - For LATENCY=1 the access is performed on the accept edge instead.
- Access: word index = addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] ignored.
  - Store: write byte i iff mask[i].
  - Load: register the full word into `mem_rdata`.
- RESP: `mem_ready`=0. Pulse `mem_rvalid` (load) or `mem_wdone` (store) for exactly one cycle, then go to IDLE.
- Requests offered while `mem_ready`=0 are not accepted; the initiator holds them until `mem_ready`=1.
- Store with mask=0: completes normally, RAM unchanged.
- Reset: state=IDLE, `cnt`=0.
  - Output reset values: `mem_ready`=1, `mem_rvalid`=0, `mem_wdone`=0, `mem_err`=0, `mem_rdata`=0.
  - RAM contents are not reset.
  - Reset during BUSY aborts the request; a store not yet committed is dropped.

## Timing
- Accept at edge T (IDLE ∧ `mem_valid`). Response pulse is high in cycle T+LATENCY.
- Next accept is possible at edge T+LATENCY+1, so throughput is one request per LATENCY+1 cycles.
- `mem_rdata` updates on the same edge that raises `mem_rvalid`.
- A store is visible to a load accepted after its `mem_wdone`.
- All outputs are registered or state-decoded; there is no combinational path from request inputs to outputs.

## Configuration
- `YSYX_23060332_DMEM_ERR_EN` defined:
  - byte address ≥ DEPTH_WORDS*4 sets `mem_err` with the response pulse;
  - a failing store does not write; a failing load returns `mem_rdata`=0.
- Macro undefined:
  - `mem_err` is tied 0;
  - addresses wrap modulo DEPTH_WORDS*4 via index truncation.

## Structure
- Shared define file holds `MemAddrBus`, `MemDataBus`, `WriteEnable`/`WriteDisable`, `ZeroWord`, and the FSM state encodings (IDLE=2'd0, BUSY=2'd1, RESP=2'd2).
- One sub-module, `ysyx_23060332_dmem_ram`: a synchronous single-port word RAM with per-byte write enables and registered read. The FSM and counter live in the top.

## Test plan
- Reset then IDLE: `mem_ready`=1 and all pulses 0. Load 0x0 accepted at T → `mem_rvalid` only at T+2 (LATENCY=2); `mem_ready` low at T+1 and T+2.
- Store 0x0000_0010 ← 0xDEADBEEF, mask 0x0F, then load 0x10 → `mem_wdone` pulse, then `mem_rdata`=0xDEADBEEF.
- Store 0x10 ← 0x11223344 with mask 0x05, then load 0x10 → 0xDE22BE44.
- Hold `mem_valid` during BUSY with a second request → it is accepted only after RESP; exactly two response pulses occur.
- Assert `rst` one cycle after a store is accepted, then load the same address → old data returned and no `mem_wdone` seen.
- With the macro defined, load 0x1000 (DEPTH_WORDS=1024) → `mem_rvalid`=1, `mem_err`=1, `mem_rdata`=0. Without the macro, the same load returns the word at 0x0.
